// File: rtl/tx_request_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tx_request_scheduler_pkg
//   Shared definitions for the TX request scheduler slice:
//   - FSM state encoding (legacy 2-bit constants)
//   - source indices for the three frame producers
//   - default source count and watchdog limit
//   - idx_width(): index width helper that never returns 0
// ---------------------------------------------------------------------------
package tx_request_scheduler_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // Source indices on rqst_i / rqst_o / src_* vectors
  localparam int SRC_CHA  = 0;
  localparam int SRC_CHB  = 1;
  localparam int SRC_TRIG = 2;

  localparam int NUM_SOURCES_DEF    = 3;
  localparam int TIMEOUT_CYCLES_DEF = 50000;

  // Width of an index into n sources; a single source still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_request_scheduler_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Searches the pending vector starting
//   at the source after `last` and wrapping around, so the source served last
//   has the lowest priority.
//
//   Ports
//     pending  in   SOURCES  queued requests
//     last     in   IDX_W    index of the most recently served source
//     grant    out  SOURCES  one-hot grant (0 when nothing pending)
//     idx      out  IDX_W    index of the granted source
//     found    out  1        a source was selected
// ---------------------------------------------------------------------------
module rr_picker
  import tx_request_scheduler_pkg::*;
#(
  parameter int SOURCES = NUM_SOURCES_DEF,
  parameter int IDX_W   = idx_width(SOURCES)
) (
  input  logic [SOURCES-1:0] pending,
  input  logic [IDX_W-1:0]   last,
  output logic [SOURCES-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // cand[i] is the i-th source to look at, counting from the one after `last`.
  logic [IDX_W-1:0] cand [SOURCES];

  for (genvar i = 0; i < SOURCES; i++) begin : g_cand
    assign cand[i] = IDX_W'((int'(last) + i + 1) % SOURCES);
  end

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < SOURCES; i++) begin
      if (!found && pending[cand[i]]) begin
        found           = 1'b1;
        idx             = cand[i];
        grant[cand[i]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_request_scheduler.sv
// ---------------------------------------------------------------------------
// tx_request_scheduler
//   Queues one-cycle host requests from several frame sources, serves them in
//   round-robin order and streams the selected source's beats to the FT245
//   path. A watchdog abandons a frame that stalls for TIMEOUT_CYCLES cycles.
//
//   Ports
//     clk        in   1                     system clock (rising edge)
//     rst        in   1                     asynchronous reset, active low
//     rqst_i     in   SOURCES               host request pulses (0 chA, 1 chB, 2 trig)
//     abort_i    in   1                     cancel queued and active work
//     rqst_o     out  SOURCES               one-cycle start pulse to selected source
//     src_data   in   SOURCES*TX_DATA_WIDTH packed source beats, source k at [k*W +: W]
//     src_rdy    in   SOURCES               source beat valid
//     src_eof    in   SOURCES               source beat is last of frame
//     src_ack    out  SOURCES               beat accepted (active source only)
//     tx_data    out  TX_DATA_WIDTH         beat to FT245 path
//     tx_rdy     out  1                     tx_data valid
//     tx_eof     out  1                     tx beat is last of frame
//     tx_ack     in   1                     FT245 path accepted the beat
//     busy_o     out  1                     scheduler not idle
//     timeout_o  out  1                     one-cycle pulse when a frame is abandoned
// ---------------------------------------------------------------------------
module tx_request_scheduler
  import tx_request_scheduler_pkg::*;
#(
  parameter int SOURCES        = NUM_SOURCES_DEF,
  parameter int TX_DATA_WIDTH  = 8,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [SOURCES-1:0]                 rqst_i,
  input  logic                               abort_i,
  output logic [SOURCES-1:0]                 rqst_o,
  input  logic [SOURCES*TX_DATA_WIDTH-1:0]   src_data,
  input  logic [SOURCES-1:0]                 src_rdy,
  input  logic [SOURCES-1:0]                 src_eof,
  output logic [SOURCES-1:0]                 src_ack,
  output logic [TX_DATA_WIDTH-1:0]           tx_data,
  output logic                               tx_rdy,
  output logic                               tx_eof,
  input  logic                               tx_ack,
  output logic                               busy_o,
  output logic                               timeout_o
);

  localparam int IDX_W = idx_width(SOURCES);

  // Registered state
  logic [1:0]               state_q;
  logic [SOURCES-1:0]       pending_q;
  logic [IDX_W-1:0]         sel_q;
  logic [IDX_W-1:0]         ptr_q;      // last served source
  logic [TIMEOUT_WIDTH-1:0] wd_q;

  // Next-state / decode
  logic [1:0]               state_d;
  logic [SOURCES-1:0]       pending_d;
  logic [SOURCES-1:0]       pick_grant;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_found;
  logic                     in_stream;
  logic                     issue_go;
  logic                     beat_acc;
  logic                     frame_end;
  logic                     wd_expire;

  logic [TX_DATA_WIDTH-1:0] src_beat [SOURCES];

  for (genvar k = 0; k < SOURCES; k++) begin : g_unpack
    assign src_beat[k] = src_data[k*TX_DATA_WIDTH +: TX_DATA_WIDTH];
  end

  rr_picker #(
    .SOURCES (SOURCES),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .pending (pending_q),
    .last    (ptr_q),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .found   (pick_found)
  );

  assign in_stream = (state_q == ST_STREAM);
  assign busy_o    = (state_q != ST_IDLE);

  // An abort in IDLE must not launch a new frame.
  assign issue_go  = (state_q == ST_IDLE) && pick_found && !abort_i;

  assign beat_acc  = tx_rdy && tx_ack;
  assign frame_end = beat_acc && tx_eof;
  assign wd_expire = in_stream && !beat_acc &&
                     (wd_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Combinational only: the pulse coincides with the last STREAM cycle and
  // is naturally zero under reset, since the state flop is forced to IDLE.
  assign timeout_o = wd_expire;

  // Zero-latency beat mux; everything is forced low outside STREAM.
  always_comb begin
    tx_data = '0;
    tx_rdy  = 1'b0;
    tx_eof  = 1'b0;
    src_ack = '0;
    if (in_stream) begin
      tx_data = src_beat[sel_q];
      tx_rdy  = src_rdy[sel_q];
      tx_eof  = src_eof[sel_q];
      if (tx_ack && src_rdy[sel_q]) begin
        src_ack = SOURCES'(1) << sel_q;
      end
    end
  end

  // Pending: new requests win over the clear of the source being issued, so
  // a request landing on the issue edge keeps that source queued.
  always_comb begin
    pending_d = pending_q;
    if (abort_i) begin
      pending_d = '0;
    end else begin
      if (issue_go) begin
        pending_d = pending_d & ~pick_grant;
      end
      pending_d = pending_d | rqst_i;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (issue_go) state_d = ST_ISSUE;
        ST_ISSUE:  state_d = ST_STREAM;
        ST_STREAM: if (frame_end || wd_expire) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      ptr_q     <= IDX_W'(SOURCES - 1);
      wd_q      <= '0;
      rqst_o    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rqst_o    <= issue_go ? pick_grant : '0;
      if (issue_go) begin
        sel_q <= pick_idx;
        ptr_q <= pick_idx;
      end
      // Cleared outside STREAM (which covers entry) and on every accepted beat.
      if (!in_stream || beat_acc) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/tx_request_scheduler.md
TX_REQUEST_SCHEDULER -- requirements
Module: tx_request_scheduler

Interface
REQ-001 Parameters: SOURCES, default 3, number of frame sources; TX_DATA_WIDTH, default 8, beat width; TIMEOUT_WIDTH, default 16, watchdog counter width; TIMEOUT_CYCLES, default 50000, idle cycles allowed between beats before a frame is abandoned.
REQ-002 Ports (clock and reset first):
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
rqst_i  in  SOURCES  one-cycle host request pulses; bit 0 chA, bit 1 chB, bit 2 trigger status.
abort_i  in  1  host stop; cancels all queued and active work.
rqst_o  out  SOURCES  one-cycle start pulse to the selected source.
src_data  in  SOURCES*TX_DATA_WIDTH  packed source beats; source k in bits [k*W +: W].
src_rdy  in  SOURCES  source beat valid.
src_eof  in  SOURCES  source beat is the last of its frame.
src_ack  out  SOURCES  beat accepted, returned to the active source only.
tx_data  out  TX_DATA_WIDTH  beat to the FT245 path.
tx_rdy  out  1  tx_data valid.
tx_eof  out  1  current beat is the last of its frame.
tx_ack  in  1  FT245 path accepted the beat.
busy_o  out  1  high in every state other than IDLE.
timeout_o  out  1  one-cycle pulse when a frame is abandoned.
REQ-003 The design SHALL use one clock and an asynchronous, active-low reset rst; all flops are clocked on the rising edge of clk.

Function
REQ-004 A pending register (SOURCES bits) SHALL set bit k on rqst_i[k]; repeated requests for a queued source SHALL collapse into one entry.
REQ-005 The FSM SHALL have states IDLE, ISSUE, STREAM, with transitions: IDLE->ISSUE when pending is non-zero; ISSUE->STREAM after one cycle; STREAM->IDLE on frame end, timeout or abort.
REQ-006 On IDLE->ISSUE the scheduler SHALL latch sel as the first pending source in round-robin order, starting after the last served source; the first selection after reset starts at source 0.
REQ-007 rqst_o[sel] SHALL be high for exactly the one ISSUE cycle (registered), and pending[sel] SHALL clear at the same edge.
REQ-008 In STREAM: tx_data = src_data[sel]; tx_rdy = src_rdy[sel]; tx_eof = src_eof[sel]; src_ack[sel] = tx_ack & tx_rdy; all other src_ack bits are 0. This mux is combinational, with zero added latency.
REQ-009 Outside STREAM, tx_rdy, tx_eof and every src_ack bit SHALL be 0, and tx_data SHALL be 0.
REQ-010 A frame ends on the cycle where tx_rdy & tx_ack & tx_eof; the state SHALL be IDLE on the next edge.
REQ-011 The watchdog SHALL clear on entry to STREAM and on every accepted beat, and increment otherwise while in STREAM.
REQ-012 When the watchdog reaches TIMEOUT_CYCLES-1 without an accepted beat, the scheduler SHALL pulse timeout_o for one cycle and go to IDLE; the abandoned source is not re-queued.
REQ-013 When rqst_i[k] coincides with the clearing of pending[k] in ISSUE, the set SHALL win and k stays queued.
REQ-014 abort_i SHALL clear pending and force IDLE on the next edge from any state; a beat acknowledged in the abort cycle completes normally. rqst_i in the abort cycle is discarded.
REQ-015 The latency from an rqst_i pulse in IDLE with empty pending (cycle 0) SHALL be: pending visible cycle 1, ISSUE with rqst_o high cycle 2, STREAM from cycle 3.

Reset
REQ-016 While rst is low: state IDLE, pending 0, sel 0, round-robin pointer at the last source (so source 0 is first), watchdog 0, rqst_o 0, timeout_o 0, busy_o 0, all tx_* and src_ack outputs 0.
REQ-017 Reset asserted mid-frame SHALL abandon the frame without timeout_o and without any further src_ack.

Structure
REQ-018 The state encoding, the source indices (CHA=0, CHB=1, TRIG=2) and the TIMEOUT_CYCLES default SHALL live in the shared HDL defines file.
REQ-019 A single sub-module, rr_picker (combinational round-robin selector: pending and pointer in, one-hot grant and index out), is natural; everything else stays flat.

Verification
REQ-020 Single request: rqst_i=001 at cycle 0; source 0 sends 4 beats with eof on the 4th and tx_ack held high -> rqst_o=001 at cycle 2; 4 beats on tx; busy_o low after the last beat.
REQ-021 Fairness: rqst_i=111 in one cycle -> rqst_o order 001, 010, 100, each issued only after the previous frame's eof beat is accepted.
REQ-022 Collapse and coincidence: rqst_i[1] pulsed 3 times while source 0 streams -> exactly one source-1 frame; rqst_i[1] pulsed during its own ISSUE cycle -> a second source-1 frame follows.
REQ-023 Timeout: TIMEOUT_CYCLES=16; source stalls src_rdy=0 after 2 beats -> timeout_o pulses 16 cycles after the last accepted beat; state IDLE; the next pending source is served.
REQ-024 Backpressure and abort: tx_ack low for 5 cycles mid-frame -> tx_data stable and no src_ack; abort_i during STREAM with pending=110 -> IDLE next edge, pending 0, no rqst_o follows.
REQ-025 Async reset asserted mid-beat -> all outputs 0 immediately without waiting for clk; the first request after release is served in REQ-015 timing.
